// File: rtl/perf_pkg.sv
// perf_pkg: shared types and defaults for the measurement-window controller.
package perf_pkg;
    localparam int COUNTER_WIDTH_DEFAULT = 32;
    typedef enum logic [1:0] {IDLE, WARMUP, RUN, DONE} perf_state_e;
    typedef enum logic [1:0] {WINDOW = 2'd0, TARGET = 2'd1, ABORT = 2'd2} perf_status_e;
endpackage

// File: rtl/perf_window_ctrl.sv
// perf_window_ctrl: sequences warm-up, counter snapshot and windowed delta measurement
// over free-running performance counters, returning results through valid/ready.
module perf_window_ctrl
    import perf_pkg::*;
#(
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [COUNTER_WIDTH-1:0] cfg_warmup_cycles,
    input  logic [COUNTER_WIDTH-1:0] cfg_window_cycles,
    input  logic [COUNTER_WIDTH-1:0] cfg_target_blocks,
    input  logic [COUNTER_WIDTH-1:0] blocks_processed,
    input  logic [COUNTER_WIDTH-1:0] cycles_elapsed,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [COUNTER_WIDTH-1:0] res_blocks,
    output logic [COUNTER_WIDTH-1:0] res_cycles,
    output logic [1:0]               res_status
);
    perf_state_e               state_q, state_d;
    perf_status_e              status_q, status_d;
    logic [COUNTER_WIDTH-1:0]  warm_q, warm_d, win_q, win_d, tgt_q, tgt_d;
    logic [COUNTER_WIDTH-1:0]  base_blk_q, base_blk_d, base_cyc_q, base_cyc_d;
    logic [COUNTER_WIDTH-1:0]  res_blk_q, res_blk_d, res_cyc_q, res_cyc_d;
    logic                      valid_q, valid_d, busy_q, busy_d;
    logic [COUNTER_WIDTH-1:0]  d_blocks, d_cycles;
    logic                      hit_tgt, hit_win;

    // Modular subtraction keeps counter wrap-around transparent.
    assign d_blocks = blocks_processed - base_blk_q;
    assign d_cycles = cycles_elapsed - base_cyc_q;
    assign hit_tgt  = (tgt_q != '0) && (d_blocks >= tgt_q);
    assign hit_win  = (win_q != '0) && (d_cycles >= win_q);

    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        warm_d     = warm_q;
        win_d      = win_q;
        tgt_d      = tgt_q;
        base_blk_d = base_blk_q;
        base_cyc_d = base_cyc_q;
        res_blk_d  = res_blk_q;
        res_cyc_d  = res_cyc_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE: if (start) begin
                win_d      = cfg_window_cycles;
                tgt_d      = cfg_target_blocks;
                warm_d     = cfg_warmup_cycles;
                state_d    = (cfg_warmup_cycles != '0) ? WARMUP : RUN;
                base_blk_d = blocks_processed;
                base_cyc_d = cycles_elapsed;
            end
            WARMUP: begin
                warm_d     = warm_q - 1'b1;
                base_blk_d = blocks_processed;
                base_cyc_d = cycles_elapsed;
                if (abort) begin
                    state_d   = DONE;
                    status_d  = ABORT;
                    res_blk_d = '0;
                    res_cyc_d = '0;
                    valid_d   = 1'b1;
                end else if (warm_d == '0) begin
                    state_d = RUN;
                end
            end
            RUN: if (abort || hit_tgt || hit_win) begin
                state_d   = DONE;
                status_d  = abort ? ABORT : (hit_tgt ? TARGET : WINDOW);
                res_blk_d = d_blocks;
                res_cyc_d = d_cycles;
                valid_d   = 1'b1;
            end
            DONE: if (res_ready) begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == WARMUP) || (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            status_q   <= WINDOW;
            warm_q     <= '0;
            win_q      <= '0;
            tgt_q      <= '0;
            base_blk_q <= '0;
            base_cyc_q <= '0;
            res_blk_q  <= '0;
            res_cyc_q  <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            warm_q     <= warm_d;
            win_q      <= win_d;
            tgt_q      <= tgt_d;
            base_blk_q <= base_blk_d;
            base_cyc_q <= base_cyc_d;
            res_blk_q  <= res_blk_d;
            res_cyc_q  <= res_cyc_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign res_valid  = valid_q;
    assign res_blocks = res_blk_q;
    assign res_cycles = res_cyc_q;
    assign res_status = status_q;
endmodule

// File: tb/tb_perf_window_ctrl.sv
// tb_perf_window_ctrl: directed and randomized measurements checked against a
// per-edge history scan of the counter stimulus.
module tb_perf_window_ctrl;
    localparam int LIM = 400;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, res_ready = 1'b0;
    logic [31:0] cfg_w = '0, cfg_win = '0, cfg_tgt = '0, blk_v = '0, cyc_v = '0;
    logic        busy, res_valid;
    logic [31:0] res_blocks, res_cycles;
    logic [1:0]  res_status;
    int          checks = 0, failures = 0;
    logic [31:0] blk_a [0:LIM];
    logic [31:0] cyc_a [0:LIM];
    bit          abt_a [0:LIM];
    logic [31:0] xb, xc;
    logic [1:0]  xs;
    int          te, xe;

    always #5 clk = ~clk;

    perf_window_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_warmup_cycles(cfg_w), .cfg_window_cycles(cfg_win), .cfg_target_blocks(cfg_tgt),
        .blocks_processed(blk_v), .cycles_elapsed(cyc_v),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_blocks(res_blocks), .res_cycles(res_cycles), .res_status(res_status)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc_v = cyc_v + 1;
    endtask

    // Build the counter/abort history one measurement will see; index = edge after start.
    task automatic prep(input int mode, input int abort_at, input bit wrap);
        cyc_a[0] = wrap ? 32'hFFFF_FFF0 : cyc_v;
        blk_a[0] = blk_v;
        abt_a[0] = 1'b0;
        for (int n = 1; n <= LIM; n++) begin
            cyc_a[n] = cyc_a[n-1] + 1;
            blk_a[n] = blk_a[n-1] + ((mode == 1) ? 32'(n % 4 == 0) :
                                     (mode == 2) ? 32'd1 :
                                     (mode == 3) ? 32'($urandom_range(0, 1)) : 32'd0);
            abt_a[n] = (n == abort_at);
        end
    endtask

    task automatic measure(input int w, input logic [31:0] win, input logic [31:0] tgt);
        int r;
        logic [31:0] db, dc;
        cfg_w = 32'(w); cfg_win = win; cfg_tgt = tgt;
        te = -1;
        for (int n = 0; n <= LIM; n++) begin
            start = (n == 0);
            abort = abt_a[n];
            cyc_v = cyc_a[n];
            blk_v = blk_a[n];
            if (n == 1) begin
                cfg_w = $urandom; cfg_win = $urandom; cfg_tgt = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (n == 0) chk("busy_after_start", 32'(busy), 32'd1);
            if (res_valid) begin
                te = n;
                break;
            end
        end
        cyc_v = cyc_v + 1;
        // Reference: abort anywhere in warm-up wins; afterwards first edge meeting a rule.
        xe = -1; xb = '0; xc = '0; xs = 2'd0;
        for (int e = 1; e <= w && xe < 0; e++)
            if (abt_a[e]) begin xe = e; xs = 2'd2; end
        r = w;
        for (int e = r + 1; e <= LIM && xe < 0; e++) begin
            db = blk_a[e] - blk_a[r];
            dc = cyc_a[e] - cyc_a[r];
            if (abt_a[e]) begin xe = e; xs = 2'd2; xb = db; xc = dc; end
            else if (tgt != 0 && db >= tgt) begin xe = e; xs = 2'd1; xb = db; xc = dc; end
            else if (win != 0 && dc >= win) begin xe = e; xs = 2'd0; xb = db; xc = dc; end
        end
        chk("term_edge", 32'(te), 32'(xe));
        if (te >= 0) begin
            chk("res_blocks", res_blocks, xb);
            chk("res_cycles", res_cycles, xc);
            chk("res_status", 32'(res_status), 32'(xs));
            chk("busy_at_valid", 32'(busy), 32'd0);
        end
    endtask

    task automatic handshake(input int hold);
        for (int i = 0; i < hold; i++) begin
            start = i[0];
            tick();
            start = 1'b0;
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_busy", 32'(busy), 32'd0);
            chk("hold_blocks", res_blocks, xb);
            chk("hold_cycles", res_cycles, xc);
            chk("hold_status", 32'(res_status), 32'(xs));
        end
        res_ready = 1'b1;
        start = 1'b1;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
        chk("hs_valid_low", 32'(res_valid), 32'd0);
        chk("hs_data_kept", res_cycles, xc);
        tick();
        chk("hs_start_dropped", 32'(busy), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", res_blocks | res_cycles | 32'(res_status), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_ignored", 32'(busy | res_valid), 32'd0);

        prep(0, -1, 1'b0);
        measure(0, 100, 0);
        chk("t1_edge", 32'(te), 32'd100);
        chk("t1_cycles", res_cycles, 32'd100);
        handshake(10);

        prep(1, -1, 1'b0);
        measure(0, 0, 10);
        chk("t2_blocks", res_blocks, 32'd10);
        chk("t2_cycles", res_cycles, 32'd40);
        handshake(1);

        prep(2, -1, 1'b0);
        measure(50, 20, 0);
        chk("t3_blocks", res_blocks, 32'd20);
        chk("t3_cycles", res_cycles, 32'd20);
        handshake(1);

        prep(0, -1, 1'b1);
        measure(0, 32, 0);
        chk("t4_wrap_cycles", res_cycles, 32'd32);
        handshake(1);

        prep(2, -1, 1'b0);
        measure(0, 15, 15);
        chk("t5_tgt_prio", 32'(res_status), 32'd1);
        handshake(1);
        prep(2, 15, 1'b0);
        measure(0, 15, 15);
        chk("t5_abort_prio", 32'(res_status), 32'd2);
        handshake(1);
        prep(2, 10, 1'b0);
        measure(30, 5, 0);
        chk("t5_warm_abort", res_blocks | res_cycles, 32'd0);
        handshake(1);

        for (int k = 0; k < 8; k++) begin
            int w, ab;
            logic [31:0] win, tgt;
            w   = $urandom_range(0, 10);
            win = 32'($urandom_range(0, 60));
            tgt = 32'($urandom_range(0, 30));
            ab  = ($urandom_range(0, 3) == 0 || (win == 0 && tgt == 0)) ?
                  w + $urandom_range(1, 40) : -1;
            prep(3, ab, 1'b0);
            measure(w, win, tgt);
            handshake($urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of an unbounded window.
        cfg_w = '0; cfg_win = '0; cfg_tgt = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(res_valid), 32'd0);
        chk("arst_data", res_blocks | res_cycles | 32'(res_status), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        prep(1, -1, 1'b0);
        measure(0, 0, 10);
        chk("post_rst_blocks", res_blocks, 32'd10);
        handshake(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
